// File: rtl/ace_ccu_pkg.sv
// ace_ccu_pkg
//   Shared types for the CCU snoop scheduler.
//   sched_state_e    : scheduler FSM states
//   inflight_entry_t : one in-flight table entry (valid + cacheline address)
//   line_of()        : cacheline address of a byte address
//   Line addresses are carried in a fixed 64-bit field, so AddrWidth must be <= 64.
package ace_ccu_pkg;

    localparam int unsigned LINE_MAX_W = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic                  valid;
        logic [LINE_MAX_W-1:0] line;
    } inflight_entry_t;

    function automatic logic [LINE_MAX_W-1:0] line_of(input logic [LINE_MAX_W-1:0] addr,
                                                      input int unsigned          offset);
        return addr >> offset;
    endfunction

endpackage

// File: rtl/ace_ccu_inflight_table.sv
// ace_ccu_inflight_table
//   Table of cachelines currently being snooped/serviced.
//   Ports:
//     clk_i, rst_ni    clock, async active-low reset
//     req_addr_i       all request addresses, packed per port
//     conflict_o       per port: line already present in a valid slot
//     full_o           every slot valid
//     free_slot_o      lowest invalid slot (0 when full)
//     cnt_o            number of valid slots
//     alloc_i/...      write {valid, line(alloc_addr_i)} into alloc_slot_i
//     release_i/...    clear valid of release_slot_i
//   All outputs derive from registered state only; updates show up one cycle later.
module ace_ccu_inflight_table
    import ace_ccu_pkg::*;
#(
    parameter int unsigned NoReqs         = 4,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned CachelineBytes = 64,
    parameter int unsigned MaxInflight    = 4,
    parameter int unsigned SlotW          = 2,
    parameter int unsigned CntW           = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NoReqs*AddrWidth-1:0] req_addr_i,
    output logic [NoReqs-1:0]           conflict_o,
    output logic                        full_o,
    output logic [SlotW-1:0]            free_slot_o,
    output logic [CntW-1:0]             cnt_o,
    input  logic                        alloc_i,
    input  logic [SlotW-1:0]            alloc_slot_i,
    input  logic [AddrWidth-1:0]        alloc_addr_i,
    input  logic                        release_i,
    input  logic [SlotW-1:0]            release_slot_i
);

    localparam int unsigned LineOff = $clog2(CachelineBytes);

    inflight_entry_t tbl_q [MaxInflight];

    // Release and alloc never hit the same slot: alloc only targets slots
    // that were invalid in registered state, and releasing those is illegal.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < MaxInflight; s++) begin
                tbl_q[s] <= '0;
            end
        end else begin
            if (release_i) begin
                tbl_q[release_slot_i].valid <= 1'b0;
            end
            if (alloc_i) begin
                tbl_q[alloc_slot_i] <= '{valid: 1'b1,
                                         line:  line_of(LINE_MAX_W'(alloc_addr_i), LineOff)};
            end
        end
    end

    always_comb begin
        conflict_o = '0;
        for (int p = 0; p < NoReqs; p++) begin
            for (int s = 0; s < MaxInflight; s++) begin
                if (tbl_q[s].valid &&
                    tbl_q[s].line == line_of(LINE_MAX_W'(req_addr_i[p*AddrWidth +: AddrWidth]),
                                             LineOff)) begin
                    conflict_o[p] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic found;
        found       = 1'b0;
        free_slot_o = '0;
        for (int s = 0; s < MaxInflight; s++) begin
            if (!tbl_q[s].valid && !found) begin
                free_slot_o = SlotW'(s);
                found       = 1'b1;
            end
        end
        full_o = ~found;
    end

    always_comb begin
        cnt_o = '0;
        for (int s = 0; s < MaxInflight; s++) begin
            cnt_o = cnt_o + CntW'(tbl_q[s].valid);
        end
    end

    // Releasing a slot that holds nothing points at an FSM bookkeeping bug.
    release_valid_slot: assert property (
        @(posedge clk_i) disable iff (!rst_ni) release_i |-> tbl_q[release_slot_i].valid
    );

endmodule

// File: rtl/ace_ccu_snoop_sched.sv
// ace_ccu_snoop_sched
//   Round-robin scheduler of coherent requests onto the shared snoop FSM.
//   Requests whose cacheline is already in flight are held back so that
//   same-line transactions are serialized.
//   Ports:
//     clk_i, rst_ni     clock, async active-low reset
//     req_valid_i       per-port request valid (held until ready)
//     req_addr_i        per-port request address, packed
//     req_ready_o       per-port accept, only for the granted port on handshake
//     fsm_valid_o       grant offered to the snoop FSM
//     fsm_ready_i       snoop FSM accepts the grant
//     fsm_addr_o        granted address
//     fsm_idx_o         granted port index
//     fsm_slot_o        table slot reserved for the grant
//     done_valid_i      snoop FSM finished a transaction
//     done_slot_i       slot being released
//     inflight_cnt_o    occupied slots
//     busy_o            slots occupied or a grant pending
//
//   state | meaning
//   IDLE  | arbitrate among eligible ports, latch winner into grant regs
//   GRANT | offer latched grant to snoop FSM, hold until fsm_ready_i
module ace_ccu_snoop_sched
    import ace_ccu_pkg::*;
#(
    parameter int unsigned NoReqs         = 4,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned CachelineBytes = 64,
    parameter int unsigned MaxInflight    = 4,
    localparam int unsigned IdxW  = (NoReqs > 1) ? $clog2(NoReqs) : 1,
    localparam int unsigned SlotW = (MaxInflight > 1) ? $clog2(MaxInflight) : 1,
    localparam int unsigned CntW  = $clog2(MaxInflight + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NoReqs-1:0]           req_valid_i,
    input  logic [NoReqs*AddrWidth-1:0] req_addr_i,
    output logic [NoReqs-1:0]           req_ready_o,
    output logic                        fsm_valid_o,
    input  logic                        fsm_ready_i,
    output logic [AddrWidth-1:0]        fsm_addr_o,
    output logic [IdxW-1:0]             fsm_idx_o,
    output logic [SlotW-1:0]            fsm_slot_o,
    input  logic                        done_valid_i,
    input  logic [SlotW-1:0]            done_slot_i,
    output logic [CntW-1:0]             inflight_cnt_o,
    output logic                        busy_o
);

    sched_state_e         state_q;
    logic [IdxW-1:0]      rr_q;
    logic [IdxW-1:0]      idx_q;
    logic [AddrWidth-1:0] addr_q;
    logic [SlotW-1:0]     slot_q;

    logic [NoReqs-1:0]    conflict;
    logic                 full;
    logic [SlotW-1:0]     free_slot;
    logic [CntW-1:0]      cnt;
    logic                 accept;
    logic [NoReqs-1:0]    eligible;
    logic                 pick_valid;
    logic [IdxW-1:0]      pick_idx;
    logic [AddrWidth-1:0] addr_arr [NoReqs];

    assign accept = (state_q == GRANT) && fsm_ready_i;

    ace_ccu_inflight_table #(
        .NoReqs         (NoReqs),
        .AddrWidth      (AddrWidth),
        .CachelineBytes (CachelineBytes),
        .MaxInflight    (MaxInflight),
        .SlotW          (SlotW),
        .CntW           (CntW)
    ) u_table (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_addr_i     (req_addr_i),
        .conflict_o     (conflict),
        .full_o         (full),
        .free_slot_o    (free_slot),
        .cnt_o          (cnt),
        .alloc_i        (accept),
        .alloc_slot_i   (slot_q),
        .alloc_addr_i   (addr_q),
        .release_i      (done_valid_i),
        .release_slot_i (done_slot_i)
    );

    always_comb begin
        for (int p = 0; p < NoReqs; p++) begin
            addr_arr[p] = req_addr_i[p*AddrWidth +: AddrWidth];
        end
    end

    assign eligible = req_valid_i & ~conflict & {NoReqs{~full}};

    // First eligible port at or after rr_q, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 0; k < NoReqs; k++) begin
            int unsigned j;
            j = 32'(rr_q) + k;
            if (j >= NoReqs) begin
                j = j - NoReqs;
            end
            if (!pick_valid && eligible[IdxW'(j)]) begin
                pick_valid = 1'b1;
                pick_idx   = IdxW'(j);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            slot_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        idx_q   <= pick_idx;
                        addr_q  <= addr_arr[pick_idx];
                        slot_q  <= free_slot;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (fsm_ready_i) begin
                        rr_q    <= (idx_q == IdxW'(NoReqs - 1)) ? '0 : idx_q + 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[idx_q] = 1'b1;
        end
    end

    assign fsm_valid_o    = (state_q == GRANT);
    assign fsm_addr_o     = addr_q;
    assign fsm_idx_o      = idx_q;
    assign fsm_slot_o     = slot_q;
    assign inflight_cnt_o = cnt;
    assign busy_o         = (cnt != '0) || (state_q == GRANT);

endmodule

// File: tb/tb_ace_ccu_snoop_sched.sv
// tb_ace_ccu_snoop_sched
//   Directed bench for ace_ccu_snoop_sched (4 ports, 64-bit addr, 64B lines, 4 slots).
//   A per-cycle reference model (sets of in-flight lines, a pending grant record,
//   round-robin pointer) is compared with the DUT at every falling edge; the
//   directed scenarios additionally pin hand-computed values.
module tb_ace_ccu_snoop_sched;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b1;
    logic [3:0]   req_valid_i;
    logic [255:0] req_addr_i;
    logic [3:0]   req_ready_o;
    logic         fsm_valid_o;
    logic         fsm_ready_i;
    logic [63:0]  fsm_addr_o;
    logic [1:0]   fsm_idx_o;
    logic [1:0]   fsm_slot_o;
    logic         done_valid_i;
    logic [1:0]   done_slot_i;
    logic [2:0]   inflight_cnt_o;
    logic         busy_o;

    ace_ccu_snoop_sched #(
        .NoReqs         (4),
        .AddrWidth      (64),
        .CachelineBytes (64),
        .MaxInflight    (4)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_addr_i     (req_addr_i),
        .req_ready_o    (req_ready_o),
        .fsm_valid_o    (fsm_valid_o),
        .fsm_ready_i    (fsm_ready_i),
        .fsm_addr_o     (fsm_addr_o),
        .fsm_idx_o      (fsm_idx_o),
        .fsm_slot_o     (fsm_slot_o),
        .done_valid_i   (done_valid_i),
        .done_slot_i    (done_slot_i),
        .inflight_cnt_o (inflight_cnt_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_grant;
    int          m_gport;
    int          m_gslot;
    logic [63:0] m_gaddr;
    bit          m_valid [4];
    logic [63:0] m_line  [4];
    int          m_rr;
    bit          nv [4];
    logic [63:0] nl [4];
    int          m_cnt;
    bit          m_full;
    int          mp;
    logic [3:0]  m_rdy;

    function automatic bit line_busy(input logic [63:0] ln);
        for (int s = 0; s < 4; s++) begin
            if (m_valid[s] && m_line[s] == ln) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int first_free();
        for (int s = 0; s < 4; s++) begin
            if (!m_valid[s]) return s;
        end
        return 0;
    endfunction

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            m_grant = 0;
            m_rr    = 0;
            for (int s = 0; s < 4; s++) begin
                m_valid[s] = 0;
                m_line[s]  = '0;
            end
            chk("rst_fsm_valid", 64'(fsm_valid_o), 64'd0);
            chk("rst_req_ready", 64'(req_ready_o), 64'd0);
            chk("rst_fsm_addr", fsm_addr_o, 64'd0);
            chk("rst_cnt", 64'(inflight_cnt_o), 64'd0);
            chk("rst_busy", 64'(busy_o), 64'd0);
        end else begin
            m_cnt = 0;
            for (int s = 0; s < 4; s++) m_cnt += int'(m_valid[s]);
            m_rdy = (m_grant && fsm_ready_i) ? 4'(1 << m_gport) : 4'd0;
            chk("m_fsm_valid", 64'(fsm_valid_o), 64'(m_grant));
            if (m_grant) begin
                chk("m_fsm_addr", fsm_addr_o, m_gaddr);
                chk("m_fsm_idx", 64'(fsm_idx_o), 64'(m_gport));
                chk("m_fsm_slot", 64'(fsm_slot_o), 64'(m_gslot));
            end
            chk("m_req_ready", 64'(req_ready_o), 64'(m_rdy));
            chk("m_cnt", 64'(inflight_cnt_o), 64'(m_cnt));
            chk("m_busy", 64'(busy_o), 64'((m_cnt != 0) || m_grant));

            // advance model by one clock using the inputs stable at this point
            nv = m_valid;
            nl = m_line;
            if (done_valid_i && m_valid[done_slot_i]) nv[done_slot_i] = 0;
            if (m_grant) begin
                if (fsm_ready_i) begin
                    nv[m_gslot] = 1;
                    nl[m_gslot] = m_gaddr >> 6;
                    m_rr        = (m_gport + 1) % 4;
                    m_grant     = 0;
                end
            end else begin
                m_full = 1;
                for (int s = 0; s < 4; s++) if (!m_valid[s]) m_full = 0;
                if (!m_full) begin
                    for (int k = 0; k < 4; k++) begin
                        mp = (m_rr + k) % 4;
                        if (!m_grant && req_valid_i[mp] &&
                            !line_busy(req_addr_i[mp*64 +: 64] >> 6)) begin
                            m_grant = 1;
                            m_gport = mp;
                            m_gaddr = req_addr_i[mp*64 +: 64];
                            m_gslot = first_free();
                        end
                    end
                end
            end
            m_valid = nv;
            m_line  = nl;
        end
    end

    // ---------------- stimulus ----------------
    logic        s_fv;
    logic [1:0]  s_idx;
    logic [1:0]  s_slot;
    logic [3:0]  s_rdy;
    logic [2:0]  s_cnt;
    logic [63:0] s_addr;
    int          g;

    // One clock: sample outputs mid-cycle, then drop accepted requests and done pulse.
    task automatic step();
        @(negedge clk_i);
        s_fv   = fsm_valid_o;
        s_idx  = fsm_idx_o;
        s_slot = fsm_slot_o;
        s_rdy  = req_ready_o;
        s_cnt  = inflight_cnt_o;
        s_addr = fsm_addr_o;
        @(posedge clk_i);
        #1;
        req_valid_i  = req_valid_i & ~s_rdy;
        done_valid_i = 1'b0;
    endtask

    task automatic set_req(input int p, input logic [63:0] a);
        req_addr_i[p*64 +: 64] = a;
        req_valid_i[p]         = 1'b1;
    endtask

    task automatic do_reset();
        req_valid_i = '0;
        rst_ni      = 1'b0;
        repeat (2) step();
        rst_ni = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        req_valid_i  = '0;
        req_addr_i   = '0;
        fsm_ready_i  = 1'b1;
        done_valid_i = 1'b0;
        done_slot_i  = '0;
        #1 rst_ni = 1'b0;
        repeat (2) step();
        chk("t0_fsm_valid", 64'(s_fv), 64'd0);
        chk("t0_cnt", 64'(s_cnt), 64'd0);
        rst_ni = 1'b1;

        // 1: four ports, distinct lines, FSM always ready
        for (int p = 0; p < 4; p++) set_req(p, 64'h10000 + 64'(p) * 64'h40);
        g = 0;
        for (int c = 0; c < 9; c++) begin
            step();
            if (s_fv) begin
                if (g < 4) begin
                    chk("t1_cycle", 64'(c), 64'(1 + 2 * g));
                    chk("t1_idx", 64'(s_idx), 64'(g));
                    chk("t1_slot", 64'(s_slot), 64'(g));
                end
                g++;
            end
        end
        chk("t1_grants", 64'(g), 64'd4);
        chk("t1_cnt", 64'(s_cnt), 64'd4);

        // 3: table full, port 2 waits; releasing slot 1 lets it in at slot 1
        set_req(2, 64'h9000);
        repeat (3) begin
            step();
            chk("t3_blocked", 64'(s_fv), 64'd0);
        end
        done_valid_i = 1'b1;
        done_slot_i  = 2'd1;
        step();
        chk("t3_done_cyc", 64'(s_fv), 64'd0);
        step();
        chk("t3_done_p1", 64'(s_fv), 64'd0);
        chk("t3_cnt_freed", 64'(s_cnt), 64'd3);
        step();
        chk("t3_grant", 64'(s_fv), 64'd1);
        chk("t3_idx", 64'(s_idx), 64'd2);
        chk("t3_slot", 64'(s_slot), 64'd1);

        // 2: same-line request waits for release, grant 2 cycles after done
        do_reset();
        set_req(0, 64'h1000);
        step();
        step();
        chk("t2_first", 64'(s_rdy), 64'h1);
        set_req(1, 64'h1020);
        repeat (4) begin
            step();
            chk("t2_blocked", 64'(s_fv), 64'd0);
        end
        done_valid_i = 1'b1;
        done_slot_i  = 2'd0;
        step();
        chk("t2_done_cyc", 64'(s_fv), 64'd0);
        step();
        chk("t2_done_p1", 64'(s_fv), 64'd0);
        step();
        chk("t2_grant", 64'(s_fv), 64'd1);
        chk("t2_idx", 64'(s_idx), 64'd1);
        chk("t2_addr", s_addr, 64'h1020);

        // 4: grant stalled by FSM for 5 cycles
        do_reset();
        fsm_ready_i = 1'b0;
        set_req(3, 64'h2000);
        step();
        chk("t4_c0", 64'(s_fv), 64'd0);
        for (int c = 1; c <= 5; c++) begin
            step();
            chk("t4_valid", 64'(s_fv), 64'd1);
            chk("t4_addr", s_addr, 64'h2000);
            chk("t4_idx", 64'(s_idx), 64'd3);
            chk("t4_slot", 64'(s_slot), 64'd0);
            chk("t4_rdy_low", 64'(s_rdy), 64'd0);
        end
        fsm_ready_i = 1'b1;
        step();
        chk("t4_pulse", 64'(s_rdy), 64'h8);
        step();
        chk("t4_after_rdy", 64'(s_rdy), 64'd0);
        chk("t4_after_valid", 64'(s_fv), 64'd0);
        chk("t4_cnt", 64'(s_cnt), 64'd1);

        // 5: done and accept in the same cycle
        fsm_ready_i = 1'b0;
        set_req(1, 64'h3000);
        step();
        step();
        chk("t5_slot", 64'(s_slot), 64'd1);
        chk("t5_cnt_before", 64'(s_cnt), 64'd1);
        fsm_ready_i  = 1'b1;
        done_valid_i = 1'b1;
        done_slot_i  = 2'd0;
        step();
        chk("t5_accept", 64'(s_rdy), 64'h2);
        step();
        chk("t5_cnt_after", 64'(s_cnt), 64'd1);
        set_req(0, 64'h2000);
        set_req(2, 64'h3010);
        step();
        step();
        chk("t5_grant", 64'(s_fv), 64'd1);
        chk("t5_idx", 64'(s_idx), 64'd0);
        chk("t5_slot0", 64'(s_slot), 64'd0);
        step();
        step();
        chk("t5_p2_blocked", 64'(s_fv), 64'd0);
        chk("t5_cnt2", 64'(s_cnt), 64'd2);

        // 6: reset during GRANT drops the grant; port re-granted afterwards
        do_reset();
        fsm_ready_i = 1'b0;
        set_req(2, 64'h4000);
        step();
        step();
        chk("t6_grant", 64'(s_fv), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(fsm_valid_o), 64'd0);
        chk("t6_rst_rdy", 64'(req_ready_o), 64'd0);
        chk("t6_rst_addr", fsm_addr_o, 64'd0);
        chk("t6_rst_idx", 64'(fsm_idx_o), 64'd0);
        chk("t6_rst_busy", 64'(busy_o), 64'd0);
        step();
        step();
        rst_ni      = 1'b1;
        fsm_ready_i = 1'b1;
        step();
        chk("t6_idle", 64'(s_fv), 64'd0);
        step();
        chk("t6_regrant", 64'(s_fv), 64'd1);
        chk("t6_idx", 64'(s_idx), 64'd2);
        chk("t6_slot", 64'(s_slot), 64'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
